pm_arbiter: RTL and testbench
=============================

# pm_arbiter

Arbiter for the single read port of program memory, shared between instruction fetch and a data-side requester that performs program-memory loads (constant tables, self-test reads). It sits between the PC stage and the program ROM and gives each cycle's port slot to one requester. It routes the one-cycle-late read data back to the owner and raises a stall so the PC holds its value while fetch is denied. Anti-starvation logic bounds how long fetch can wait.

## Interface
- `MAX_WAIT`, default 4: maximum consecutive cycles fetch may be denied while requesting; range 1..15.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `f_req`  in  1: fetch requests a read this cycle.
- `f_addr`  in  16: fetch address (PC value).
- `d_req`  in  1: data port requests a read this cycle.
- `d_addr`  in  16: data read address.
- `d_lock`  in  1: data port asks to keep the port for its next request (multi-word read); sampled only together with a data grant.
- `f_gnt`  out  1: fetch owns the port this cycle.
- `d_gnt`  out  1: data owns the port this cycle.
- `mem_addr`  out  16: address to program memory; the granted address, or 0 when idle.
- `mem_rdata`  in  16: memory read data, valid one cycle after the address (synchronous read).
- `rdata`  out  16: returned read data, shared by both requesters.
- `f_rvalid`  out  1: `rdata` answers the fetch granted in the previous cycle.
- `d_rvalid`  out  1: `rdata` answers the data read granted in the previous cycle.
- `pc_stall`  out  1: PC must not advance; equals `f_req & ~f_gnt`.

## Operation
- Grants are combinational from requests and registered state. At most one grant is high per cycle. A request with no grant is held by its requester, with the address stable, until granted.
- Arbitration, in priority order:
  - If `lock` is set and `d_req` is high, data is granted.
  - Otherwise, if `starve` is true (`wait_cnt == MAX_WAIT`) and `f_req` is high, fetch is granted.
  - Otherwise, if `d_req` is high, data is granted.
  - Otherwise, if `f_req` is high, fetch is granted.
- If `lock` is set but `d_req` is low, `lock` clears and normal arbitration applies in the same cycle.
- Starvation overrides a lock only on the cycle `starve` is true. In that case fetch is granted and `lock` clears.
- `wait_cnt` (4 bits) behaviour:
  - Increments each cycle `f_req & ~f_gnt`, saturating at `MAX_WAIT`.
  - Clears on `f_gnt`.
  - Holds when `f_req` is low.
- `lock` is set on a cycle with `d_gnt & d_lock`. It clears on a data grant without `d_lock`, on a starvation grant to fetch, or when `d_req` is low.
- Response routing:
  - `owner` register, two bits (`{f, d}`), loaded every cycle with `{f_gnt, d_gnt}`.
  - `f_rvalid = owner.f`, `d_rvalid = owner.d`.
  - `rdata = mem_rdata` (pass-through), qualified only by the rvalid signals.
- States are implicit in `{lock, starve}`: IDLE/NORMAL `{0,0}`, LOCKED `{1,0}`, STARVED `{x,1}`.

## Timing
- Grant latency: 0 cycles when the port is free.
- Data return: exactly 1 cycle after the grant; back-to-back grants give one result per cycle.
- Worst-case fetch wait while requesting: `MAX_WAIT` cycles. The grant is on cycle `MAX_WAIT`+1.
- Reset values: `wait_cnt`=0, `lock`=0, `owner`=00. Therefore `f_rvalid`=`d_rvalid`=0. With no requests, `f_gnt`=`d_gnt`=0 and `mem_addr`=0.
- Reset mid-transaction: a read granted in the cycle before reset is dropped, with no rvalid after reset. Requesters must reissue.
- Both requests at reset release: data wins unless `MAX_WAIT` is reached later.
- `pc_stall` is combinational. The PC register uses `~pc_stall` as its load enable, so the stall holds the PC in the same cycle.

## Structure
- Shared package holds the owner encoding constants (`OWN_NONE`, `OWN_F`, `OWN_D`) and the 16-bit word width constant used across PC, ROM and ALU.
- Sub-module `starve_ctr`: a saturating wait counter with clear, increment and `MAX_WAIT` compare. Everything else stays flat in `pm_arbiter`.

## Test plan
- Fetch only: `f_req`=1, `f_addr` = 0,1,2 on successive cycles → `f_gnt`=1 every cycle, `pc_stall`=0, `f_rvalid`=1 from cycle 2 with `rdata` = ROM[0], ROM[1], ROM[2].
- Collision: `f_req`=`d_req`=1 with `d_addr`=0x0040 for one cycle → `d_gnt`=1, `pc_stall`=1, `mem_addr`=0x0040. The next cycle gives `f_gnt`=1, and `d_rvalid`=1 with `rdata`=ROM[0x40].
- Starvation: `MAX_WAIT`=4, both requesting continuously → 4 data grants, then `f_gnt` on cycle 5, then `wait_cnt`=0 and data wins again.
- Lock: `d_lock`=1 for 3 words while `f_req`=1, `MAX_WAIT`=4 → 3 consecutive `d_gnt`. After lock release, `f_gnt`, with `pc_stall` high for 3 cycles.
- Lock override: `d_lock`=1 held continuously with `MAX_WAIT`=2 → fetch is granted on the 3rd cycle and `lock` clears.
- Async reset: assert `rst` mid-cycle right after a data grant → `d_rvalid`=0 after release, `wait_cnt`=0, `lock`=0, no grant until new requests arrive.

Source files
------------

// File: rtl/pm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pm_arbiter_pkg
// Shared definitions for the program-memory read-port arbiter.
//   WORD_W           : data/address word width used by PC, ROM and ALU
//   owner_t          : {f, d} ownership of the port slot in a given cycle
//   OWN_NONE/F/D     : owner encodings
// -----------------------------------------------------------------------------
package pm_arbiter_pkg;

    localparam int WORD_W = 16;

    // Bit 1 = fetch, bit 0 = data. At most one bit is ever set.
    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'b00;
    localparam owner_t OWN_F    = 2'b10;
    localparam owner_t OWN_D    = 2'b01;

endpackage : pm_arbiter_pkg

// File: rtl/pm_arbiter_starve_ctr.sv
// -----------------------------------------------------------------------------
// starve_ctr
// Saturating count of consecutive cycles fetch has been denied.
//   clk    in  : system clock
//   rst    in  : asynchronous active-high reset
//   inc    in  : fetch requested but was not granted this cycle
//   clr    in  : fetch was granted this cycle (wins over inc)
//   starve out : count has reached MAX_WAIT; fetch must win next arbitration
// -----------------------------------------------------------------------------
module starve_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 4'd1;
        end
    end

    assign starve = (count == LIMIT);

endmodule : starve_ctr

// File: rtl/pm_arbiter.sv
// -----------------------------------------------------------------------------
// pm_arbiter
// Arbitrates the single program-memory read port between instruction fetch
// and a data-side requester, returns the one-cycle-late read data to the
// owner, and stalls the PC while fetch is denied.
//   MAX_WAIT  param : max consecutive denied fetch cycles (1..15)
//   clk       in    : system clock
//   rst       in    : asynchronous active-high reset
//   f_req     in    : fetch read request
//   f_addr    in    : fetch address (PC)
//   d_req     in    : data read request
//   d_addr    in    : data read address
//   d_lock    in    : keep the port for the next data request (burst)
//   f_gnt     out   : fetch owns the port this cycle
//   d_gnt     out   : data owns the port this cycle
//   mem_addr  out   : granted address, 0 when idle
//   mem_rdata in    : synchronous-read memory data (one cycle after address)
//   rdata     out   : returned read data, shared by both requesters
//   f_rvalid  out   : rdata answers last cycle's fetch grant
//   d_rvalid  out   : rdata answers last cycle's data grant
//   pc_stall  out   : PC must hold (fetch requesting but not granted)
// -----------------------------------------------------------------------------
module pm_arbiter
    import pm_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [WORD_W-1:0] f_addr,
    input  logic              d_req,
    input  logic [WORD_W-1:0] d_addr,
    input  logic              d_lock,
    output logic              f_gnt,
    output logic              d_gnt,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] rdata,
    output logic              f_rvalid,
    output logic              d_rvalid,
    output logic              pc_stall
);

    logic   starve;
    logic   lock;
    owner_t owner;

    starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (pc_stall),
        .clr    (f_gnt),
        .starve (starve)
    );

    // Grant selection. Starvation is checked first so a held lock cannot
    // block fetch beyond MAX_WAIT cycles; a lock with d_req low simply falls
    // through to normal arbitration in the same cycle.
    // NOTE: every combinational output gets a default before the if-chain, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        f_gnt    = 1'b0;
        d_gnt    = 1'b0;
        mem_addr = '0;
        if (starve && f_req) begin
            f_gnt = 1'b1;
        end else if (lock && d_req) begin
            d_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else if (f_req) begin
            f_gnt = 1'b1;
        end

        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
    end

    assign pc_stall = f_req & ~f_gnt;

    // Lock survives only while data keeps winning with d_lock set. Any other
    // outcome (data grant without d_lock, starvation grant to fetch, d_req
    // dropped) clears it, which is exactly d_gnt & d_lock.
    // Owner is reset so a read granted just before reset never returns an
    // rvalid afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock  <= 1'b0;
            owner <= OWN_NONE;
        end else begin
            lock  <= d_gnt & d_lock;
            owner <= {f_gnt, d_gnt};
        end
    end

    assign f_rvalid = |(owner & OWN_F);
    assign d_rvalid = |(owner & OWN_D);
    assign rdata    = mem_rdata;

endmodule : pm_arbiter

// File: tb/tb_pm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pm_arbiter
// Self-checking bench for pm_arbiter: directed scenarios with literal
// expectations plus randomized requesters compared every cycle against a
// behavioural model of the arbitration rules. A second instance with
// MAX_WAIT=2 covers the lock-override case.
// -----------------------------------------------------------------------------
module tb_pm_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_lock;
    logic [15:0] f_addr, d_addr;
    logic [15:0] mem_rdata;

    logic        f_gnt, d_gnt, f_rvalid, d_rvalid, pc_stall;
    logic [15:0] mem_addr, rdata;

    logic        f_gnt2, d_gnt2, f_rvalid2, d_rvalid2, pc_stall2;
    logic [15:0] mem_addr2, rdata2;

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    pm_arbiter #(.MAX_WAIT(MW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_lock    (d_lock),
        .f_gnt     (f_gnt),
        .d_gnt     (d_gnt),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .f_rvalid  (f_rvalid),
        .d_rvalid  (d_rvalid),
        .pc_stall  (pc_stall)
    );

    pm_arbiter #(.MAX_WAIT(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_lock    (d_lock),
        .f_gnt     (f_gnt2),
        .d_gnt     (d_gnt2),
        .mem_addr  (mem_addr2),
        .mem_rdata (mem_rdata),
        .rdata     (rdata2),
        .f_rvalid  (f_rvalid2),
        .d_rvalid  (d_rvalid2),
        .pc_stall  (pc_stall2)
    );

    // Program ROM contents as a pure function of the address.
    function automatic logic [15:0] rom(input logic [15:0] a);
        return ({a[7:0], ~a[7:0]} ^ 16'h1234) ^ {8'h00, a[15:8]};
    endfunction

    // Synchronous-read program memory driven by the main instance.
    always @(posedge clk) mem_rdata <= rom(mem_addr);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Fetch wins when requesting and either it has been denied MAX_WAIT
    // cycles in a row or data is not requesting; otherwise data wins.
    int          m_denied;
    logic        m_prev_f, m_prev_d;
    logic [15:0] m_prev_addr;
    logic        e_f, e_d;
    logic [15:0] e_addr;

    task model_reset();
        m_denied    = 0;
        m_prev_f    = 1'b0;
        m_prev_d    = 1'b0;
        m_prev_addr = '0;
    endtask

    // Called #1 after the negedge on which inputs were driven.
    task settle();
        #1;
        e_f    = f_req && ((m_denied == MW) || !d_req);
        e_d    = d_req && !e_f;
        e_addr = e_f ? f_addr : (e_d ? d_addr : 16'h0000);
        check("f_gnt",    {15'd0, f_gnt},    {15'd0, e_f});
        check("d_gnt",    {15'd0, d_gnt},    {15'd0, e_d});
        check("mem_addr", mem_addr,          e_addr);
        check("pc_stall", {15'd0, pc_stall}, {15'd0, f_req && !e_f});
        check("f_rvalid", {15'd0, f_rvalid}, {15'd0, m_prev_f});
        check("d_rvalid", {15'd0, d_rvalid}, {15'd0, m_prev_d});
        if (m_prev_f || m_prev_d) check("rdata", rdata, rom(m_prev_addr));
    endtask

    // Commit this cycle's outcome to the model and move to the next negedge.
    task advance();
        if (e_f) m_denied = 0;
        else if (f_req && m_denied < MW) m_denied++;
        m_prev_f    = e_f;
        m_prev_d    = e_d;
        m_prev_addr = e_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task do_reset();
        rst    = 1'b1;
        f_req  = 1'b0;
        d_req  = 1'b0;
        d_lock = 1'b0;
        f_addr = '0;
        d_addr = '0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_f_rvalid", {15'd0, f_rvalid}, 16'd0);
        check("rst_d_rvalid", {15'd0, d_rvalid}, 16'd0);
        check("rst_f_gnt",    {15'd0, f_gnt},    16'd0);
        check("rst_d_gnt",    {15'd0, d_gnt},    16'd0);
        check("rst_mem_addr", mem_addr,          16'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] rom_lit [3];
    logic        f_pend, d_pend, d_follow;
    logic [15:0] pc;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rom_lit     = '{16'h12CB, 16'h13CA, 16'h10C9};

        // Lock override (MAX_WAIT=2 instance) and starvation with lock held.
        do_reset();
        f_req = 1'b1; f_addr = 16'h0010;
        d_req = 1'b1; d_addr = 16'h0100; d_lock = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            settle();
            check($sformatf("ovr_f_gnt2_c%0d", c),    {15'd0, f_gnt2},    {15'd0, (c % 3) == 0});
            check($sformatf("ovr_d_gnt2_c%0d", c),    {15'd0, d_gnt2},    {15'd0, (c % 3) != 0});
            check($sformatf("ovr_pc_stall2_c%0d", c), {15'd0, pc_stall2}, {15'd0, (c % 3) != 0});
            check($sformatf("ovr_f_gnt_c%0d", c),     {15'd0, f_gnt},     {15'd0, c == 5});
            advance();
        end

        // Starvation without lock: 4 data grants, fetch on cycle 5, data again.
        do_reset();
        f_req = 1'b1; f_addr = 16'h0020;
        d_req = 1'b1; d_addr = 16'h0180; d_lock = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            settle();
            check($sformatf("starve_f_gnt_c%0d", c),    {15'd0, f_gnt},    {15'd0, c == 5});
            check($sformatf("starve_d_gnt_c%0d", c),    {15'd0, d_gnt},    {15'd0, c != 5});
            check($sformatf("starve_pc_stall_c%0d", c), {15'd0, pc_stall}, {15'd0, c != 5});
            advance();
        end

        // Fetch only: addresses 0,1,2 then idle.
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            f_req  = (c < 3);
            f_addr = 16'(c);
            settle();
            if (c < 3) begin
                check($sformatf("fonly_f_gnt_c%0d", c),    {15'd0, f_gnt},    16'd1);
                check($sformatf("fonly_pc_stall_c%0d", c), {15'd0, pc_stall}, 16'd0);
            end
            if (c >= 1) begin
                check($sformatf("fonly_f_rvalid_c%0d", c), {15'd0, f_rvalid}, 16'd1);
                check($sformatf("fonly_rdata_c%0d", c),    rdata,             rom_lit[c-1]);
            end
            advance();
        end

        // Collision: data wins, fetch next cycle, data read returns.
        f_req = 1'b1; f_addr = 16'h0003;
        d_req = 1'b1; d_addr = 16'h0040;
        settle();
        check("coll_d_gnt",    {15'd0, d_gnt},    16'd1);
        check("coll_pc_stall", {15'd0, pc_stall}, 16'd1);
        check("coll_mem_addr", mem_addr,          16'h0040);
        advance();
        d_req = 1'b0;
        settle();
        check("coll_f_gnt",    {15'd0, f_gnt},    16'd1);
        check("coll_d_rvalid", {15'd0, d_rvalid}, 16'd1);
        check("coll_rdata",    rdata,             16'h528B);
        advance();

        // Locked 3-word burst while fetch waits.
        f_req = 1'b1; f_addr = 16'h0004;
        for (int c = 1; c <= 4; c++) begin
            d_req  = (c <= 3);
            d_lock = (c < 3);
            d_addr = 16'h0200 + 16'(c);
            settle();
            check($sformatf("lock_d_gnt_c%0d", c),    {15'd0, d_gnt},    {15'd0, c <= 3});
            check($sformatf("lock_pc_stall_c%0d", c), {15'd0, pc_stall}, {15'd0, c <= 3});
            check($sformatf("lock_f_gnt_c%0d", c),    {15'd0, f_gnt},    {15'd0, c == 4});
            advance();
        end

        // Async reset right after a locked data grant.
        f_req = 1'b0; d_req = 1'b1; d_addr = 16'h0077; d_lock = 1'b1;
        settle();
        check("arst_d_gnt", {15'd0, d_gnt}, 16'd1);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        d_req  = 1'b0;
        d_lock = 1'b0;
        #1;
        check("arst_d_rvalid_in_rst", {15'd0, d_rvalid}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            settle();
            check($sformatf("arst_d_rvalid_c%0d", c), {15'd0, d_rvalid}, 16'd0);
            check($sformatf("arst_gnt_c%0d", c),      {14'd0, f_gnt, d_gnt}, 16'd0);
            advance();
        end

        // Randomized requesters that hold requests until granted.
        f_pend = 1'b0; d_pend = 1'b0; d_follow = 1'b0; pc = 16'h0100;
        for (int i = 0; i < 3000; i++) begin
            if (!f_pend) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = pc;
            end
            if (!d_pend) begin
                d_req  = d_follow || ($urandom_range(0, 2) == 0);
                d_addr = 16'($urandom);
                d_lock = ($urandom_range(0, 2) == 0);
            end
            settle();
            f_pend = f_req && !e_f;
            if (e_f) pc = pc + 16'd1;
            d_pend = d_req && !e_d;
            if (e_d) d_follow = d_lock;
            else if (!d_req) d_follow = 1'b0;
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pm_arbiter
